load_store_queue: RTL

- Parametrised, in-order load/store queue for the Tomasulo core.
- Sits between dispatch/decoder, the common data bus (CDB), the ROB and the memory controller.
- Generalises the first-generation LSU: configurable depth, width and CDB channel count.
- New behaviour over the first generation: multi-channel operand snooping, ROB-tagged store commit, load sign/zero extension, and a misprediction flush that preserves committed stores.

---
 rtl/load_store_queue_pkg.sv | 23 ++
 rtl/load_store_queue_load_extend.sv | 30 +++
 rtl/load_store_queue.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_queue_pkg.sv
package load_store_queue_pkg;

  localparam int unsigned OP_STORE_BIT = 3;
  localparam int unsigned OP_UNS_BIT   = 2;
  localparam int unsigned OP_WIDTH_LSB = 0;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_DRAIN = 2'd3
  } lsq_state_t;

  // Width code 3 behaves as a word access.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'd3) ? WIDTH_WORD : w;
  endfunction

endpackage

// File: rtl/load_store_queue_load_extend.sv
module lsq_load_extend
  import load_store_queue_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_width,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_value
);

  logic w_sign;

  always_comb begin
    w_sign  = 1'b0;
    o_value = i_rdata;
    case (i_width)
      WIDTH_BYTE: begin
        w_sign  = i_rdata[7] & ~i_unsigned;
        o_value = {{(XLEN-8){w_sign}}, i_rdata[7:0]};
      end
      WIDTH_HALF: begin
        w_sign  = i_rdata[15] & ~i_unsigned;
        o_value = {{(XLEN-16){w_sign}}, i_rdata[15:0]};
      end
      default: o_value = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     disp_valid,
  input  logic [3:0]               disp_op,
  input  logic [ROB_W-1:0]         disp_rob,
  input  logic [XLEN-1:0]          disp_imm,
  input  logic [XLEN-1:0]          disp_vj,
  input  logic [XLEN-1:0]          disp_vk,
  input  logic [ROB_W-1:0]         disp_qj,
  input  logic [ROB_W-1:0]         disp_qk,
  input  logic                     disp_rj,
  input  logic                     disp_rk,
  output logic                     disp_full,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_rob,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  input  logic                     commit_valid,
  input  logic [ROB_W-1:0]         commit_rob,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [1:0]               mem_width,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic                     mem_done,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     res_valid,
  output logic [ROB_W-1:0]         res_rob,
  output logic [XLEN-1:0]          res_value
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] r_valid, r_store, r_uns, r_rj, r_rk, r_committed, r_reported;
  logic [1:0]       r_width [DEPTH];
  logic [ROB_W-1:0] r_rob   [DEPTH];
  logic [ROB_W-1:0] r_qj    [DEPTH];
  logic [ROB_W-1:0] r_qk    [DEPTH];
  logic [XLEN-1:0]  r_imm   [DEPTH];
  logic [XLEN-1:0]  r_vj    [DEPTH];
  logic [XLEN-1:0]  r_vk    [DEPTH];

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  lsq_state_t    r_state;

  logic             w_full, w_pop, w_acc;
  logic             w_h_valid, w_h_store, w_h_uns, w_h_rj, w_h_rk, w_h_committed, w_h_reported;
  logic [1:0]       w_h_width;
  logic [ROB_W-1:0] w_h_rob;
  logic [XLEN-1:0]  w_h_addr, w_h_vk, w_wdata, w_ext;
  logic [XLEN-1:0]  w_dvj, w_dvk;
  logic             w_jhit, w_khit, w_drj, w_drk;
  logic [DEPTH-1:0] w_comm;
  logic [CW-1:0]    w_keep;
  logic             w_run;
  logic [PW-1:0]    w_idx;

  assign w_full    = (r_count == CW'(DEPTH));
  assign disp_full = w_full;

  assign w_h_valid     = r_valid[r_head];
  assign w_h_store     = r_store[r_head];
  assign w_h_uns       = r_uns[r_head];
  assign w_h_rj        = r_rj[r_head];
  assign w_h_rk        = r_rk[r_head];
  assign w_h_committed = r_committed[r_head];
  assign w_h_reported  = r_reported[r_head];
  assign w_h_width     = r_width[r_head];
  assign w_h_rob       = r_rob[r_head];
  assign w_h_vk        = r_vk[r_head];
  assign w_h_addr      = r_vj[r_head] + r_imm[r_head];

  assign w_pop = mem_done && ((r_state == S_STORE) || ((r_state == S_LOAD) && !flush_in));
  // A pop frees the head slot in the same cycle, so dispatch is still taken while full.
  assign w_acc = disp_valid && !flush_in && (!w_full || w_pop);

  // Same-cycle operand capture at dispatch; lowest channel wins.
  always_comb begin
    w_dvj  = disp_vj;
    w_dvk  = disp_vk;
    w_jhit = 1'b0;
    w_khit = 1'b0;
    for (int unsigned c = 0; c < NUM_CDB; c++) begin
      if (!disp_rj && !w_jhit && cdb_valid[c] && (cdb_rob[c*ROB_W +: ROB_W] == disp_qj)) begin
        w_dvj  = cdb_value[c*XLEN +: XLEN];
        w_jhit = 1'b1;
      end
      if (!disp_rk && !w_khit && cdb_valid[c] && (cdb_rob[c*ROB_W +: ROB_W] == disp_qk)) begin
        w_dvk  = cdb_value[c*XLEN +: XLEN];
        w_khit = 1'b1;
      end
    end
  end

  assign w_drj = disp_rj | w_jhit;
  assign w_drk = disp_rk | w_khit;

  always_comb begin
    w_comm = r_committed;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (commit_valid && r_valid[i] && r_store[i] && (r_rob[i] == commit_rob)) begin
        w_comm[i] = 1'b1;
      end
    end
  end

  // Length of the committed-store run starting at head (commit already applied).
  always_comb begin
    w_keep = '0;
    w_run  = 1'b1;
    w_idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if (w_run && (CW'(k) < r_count) && r_valid[w_idx] && r_store[w_idx] && w_comm[w_idx]) begin
        w_keep = w_keep + CW'(1);
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_comb begin
    case (w_h_width)
      WIDTH_BYTE: w_wdata = {{(XLEN-8){1'b0}}, w_h_vk[7:0]};
      WIDTH_HALF: w_wdata = {{(XLEN-16){1'b0}}, w_h_vk[15:0]};
      default:    w_wdata = w_h_vk;
    endcase
  end

  lsq_load_extend #(.XLEN(XLEN)) u_ext (
    .i_rdata   (mem_rdata),
    .i_width   (w_h_width),
    .i_unsigned(w_h_uns),
    .o_value   (w_ext)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_store     <= '0;
      r_uns       <= '0;
      r_rj        <= '0;
      r_rk        <= '0;
      r_committed <= '0;
      r_reported  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_width[i] <= '0;
        r_rob[i]   <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
        r_imm[i]   <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
      end
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_width <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      res_valid <= 1'b0;
      res_rob   <= '0;
      res_value <= '0;
    end else if (rdy_in) begin
      res_valid   <= 1'b0;
      r_committed <= w_comm;

      // Highest channel first so the lowest index lands last.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned c = 0; c < NUM_CDB; c++) begin
          if (r_valid[i] && cdb_valid[NUM_CDB-1-c]) begin
            if (!r_rj[i] && (r_qj[i] == cdb_rob[(NUM_CDB-1-c)*ROB_W +: ROB_W])) begin
              r_vj[i] <= cdb_value[(NUM_CDB-1-c)*XLEN +: XLEN];
              r_rj[i] <= 1'b1;
            end
            if (!r_rk[i] && (r_qk[i] == cdb_rob[(NUM_CDB-1-c)*ROB_W +: ROB_W])) begin
              r_vk[i] <= cdb_value[(NUM_CDB-1-c)*XLEN +: XLEN];
              r_rk[i] <= 1'b1;
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_h_valid && w_h_rj && w_h_rk) begin
            if (!w_h_store) begin
              if (!flush_in) begin
                r_state   <= S_LOAD;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_width <= w_h_width;
                mem_addr  <= w_h_addr;
                mem_wdata <= '0;
              end
            end else if (!w_h_reported) begin
              if (!flush_in) begin
                res_valid            <= 1'b1;
                res_rob              <= w_h_rob;
                res_value            <= '0;
                r_reported[r_head]   <= 1'b1;
              end
            end else if (w_h_committed) begin
              r_state   <= S_STORE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_width <= w_h_width;
              mem_addr  <= w_h_addr;
              mem_wdata <= w_wdata;
            end
          end
        end
        S_LOAD: begin
          if (flush_in) begin
            if (mem_done) begin
              mem_req <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (mem_done) begin
            res_valid <= 1'b1;
            res_rob   <= w_h_rob;
            res_value <= w_ext;
            mem_req   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_STORE, S_DRAIN: begin
          if (mem_done) begin
            mem_req <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
      end

      if (flush_in) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if ({1'b0, PW'(i) - r_head} >= w_keep) begin
            r_valid[i] <= 1'b0;
          end
        end
      end

      if (w_acc) begin
        r_valid[r_tail]     <= 1'b1;
        r_store[r_tail]     <= disp_op[OP_STORE_BIT];
        r_uns[r_tail]       <= disp_op[OP_UNS_BIT];
        r_width[r_tail]     <= norm_width(disp_op[OP_WIDTH_LSB +: 2]);
        r_rob[r_tail]       <= disp_rob;
        r_imm[r_tail]       <= disp_imm;
        r_vj[r_tail]        <= w_dvj;
        r_vk[r_tail]        <= w_dvk;
        r_qj[r_tail]        <= disp_qj;
        r_qk[r_tail]        <= disp_qk;
        r_rj[r_tail]        <= w_drj;
        r_rk[r_tail]        <= w_drk;
        r_committed[r_tail] <= 1'b0;
        r_reported[r_tail]  <= 1'b0;
      end

      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (flush_in) begin
        r_tail  <= r_head + w_keep[PW-1:0];
        r_count <= w_keep - CW'(w_pop);
      end else begin
        if (w_acc) begin
          r_tail <= r_tail + 1'b1;
        end
        r_count <= r_count + CW'(w_acc) - CW'(w_pop);
      end
    end
  end

endmodule
